seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Time-multiplexed driver for a four-digit common-anode 7-segment display. Consumes the four cascaded BCD digits produced by the decade counter chain (units..thousands) and scans one digit at a time. Each digit gets a one-cycle dark gap between digits to suppress ghosting. Provides snapshot loading, leading-zero blanking and invalid-code indication. Sits between the 0–9999 counter and the board pins.

## Interface
- CLK_DIV, 50000: clock cycles per digit slot; legal range ≥ 2.
- BLANK_LEADING, 1: 1 = suppress leading zeros on digits 3..1.
- ACTIVE_LOW, 1: 1 = segment and anode outputs are active-low (board default); 0 = active-high.
- iclk  in  1  system clock, rising edge.
- irst  in  1  reset, asynchronous, active-high.
- iDigits  in  16  four BCD digits; [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- iDp  in  4  decimal point per digit, same index order.
- iLoad  in  1  snapshot strobe; iDigits/iDp captured on rising iclk while high.
- iEn  in  1  scan enable.
- oSeg  out  7  segments {g,f,e,d,c,b,a}.
- oDp  out  1  decimal point segment.
- oAnodes  out  4  digit enables; bit k = digit k.
- oScanTick  out  1  one-cycle pulse at the end of each digit slot.

## Operation
- Snapshot register (16+4 bits) loads on iLoad. Display uses only the snapshot, which prevents tearing while the counter runs.
- Prescaler counts 0..CLK_DIV-1 and wraps. Tick = (count == CLK_DIV-1) && iEn.
- Digit index is 2 bits, 0→1→2→3→0. It advances on tick.
- FSM states:
  - SHOW → GAP on tick; index advances here.
  - GAP → SHOW unconditionally after 1 cycle.
- GAP drives all anodes inactive.
- Decode (gfedcba, active-high before polarity):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes A–F show dash = 40.
- Leading-zero blanking: digit k (k=1..3) is blank when BLANK_LEADING=1 and snapshot digits k..3 are all zero.
  - A blank digit drives its anode inactive during its SHOW slot.
  - Digit 0 is never blanked.
  - A non-decimal code counts as nonzero.
- oDp = snapshot iDp[index] during SHOW, inactive during GAP or while blanked.
- iEn=0:
  - Prescaler, index and state hold.
  - oAnodes inactive, oScanTick=0.
  - Snapshot loading still works.
- ACTIVE_LOW=1 inverts oSeg, oDp and oAnodes at the output register.

## Timing
- Reset (async assert) sets:
  - prescaler=0, index=0, state=SHOW, snapshot=0.
  - All outputs inactive: oAnodes=4'b1111, oSeg=7'h7F, oDp=1 with ACTIVE_LOW=1. oScanTick=0.
- oSeg, oDp, oAnodes and oScanTick are registered from (state, index, snapshot). Latency is 1 cycle from any change of these.
- The first rising edge after reset release with iEn=1 presents digit 0.
- Per slot: SHOW is visible CLK_DIV-1 cycles, then GAP is dark 1 cycle. Prescaler runs through GAP, so frame = 4·CLK_DIV cycles.
- oScanTick is asserted in the output cycle following the tick.
- iLoad during a SHOW slot updates oSeg 2 cycles after the strobe edge: snapshot reg, then output reg.
- iLoad and tick in the same cycle: both take effect. The new index displays the new snapshot.
- Reset mid-frame immediately blanks outputs and restarts at digit 0 with prescaler 0.

## Structure
- Package seg7_pkg holds:
  - the 10 digit codes and the DASH and OFF constants;
  - the state typedef {SHOW, GAP};
  - the digit index width constant.
- Sub-module seg7_decoder is pure combinational: 4-bit code → 7-bit active-high segments, dash for A–F. It is instantiated once on the muxed digit.

## Test plan
- Reset: irst high mid-scan → same cycle oAnodes=4'b1111, oSeg=7'h7F, oDp=1. Release with CLK_DIV=4, iDigits=0 → next edge oAnodes=4'b1110, oSeg=7'h40 (digit "0").
- Scan order: iLoad with 16'h1234, iDp=4'b0100, CLK_DIV=4. Required anode/seg sequence, each digit 3 cycles lit and 1 cycle dark:
  - 1110 / 19 ("4")
  - 1101 / 30 ("3")
  - 1011 / 24 ("2"), oDp=0
  - 0111 / 79 ("1")
  - oScanTick pulses every 4 cycles.
- Blanking: 16'h0007 → only digit 0 lights, with seg 78; anodes stay 1111 during digit 1–3 slots. 16'h0000 → digit 0 shows 40. With BLANK_LEADING=0, 16'h0007 → all four slots light ("0007").
- Invalid code: 16'h00A5 → digit 1 shows dash (oSeg=7'h3F), digit 0 shows "5" (12), digits 2–3 blank.
- Snapshot/enable: change iDigits without iLoad → display unchanged. Drop iEn mid-slot for 10 cycles → anodes 1111, no oScanTick. On re-enable, resumes the same digit with the same prescaler count.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment codes, scan state type and digit index width.
package seg7_pkg;
   localparam int IDX_W = 2;
   localparam logic [6:0] DASH = 7'h40;
   localparam logic [6:0] OFF  = 7'h00;
   // gfedcba, active-high; entry k is the pattern for decimal digit k
   localparam logic [9:0][6:0] DIGIT_CODES = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };
   typedef enum logic {SHOW, GAP} state_t;
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: BCD code to active-high gfedcba segments, dash for A-F.
module seg7_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] i_code,
   output logic [6:0] o_seg
);
   always_comb o_seg = (i_code < 4'd10) ? DIGIT_CODES[i_code] : DASH;
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: four-digit multiplexed 7-segment scanner with a dark gap
// between digits, snapshot register, leading-zero blanking and dash for bad codes.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int CLK_DIV       = 50000,
   parameter bit BLANK_LEADING = 1'b1,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic        iclk,
   input  logic        irst,
   input  logic [15:0] iDigits,
   input  logic [3:0]  iDp,
   input  logic        iLoad,
   input  logic        iEn,
   output logic [6:0]  oSeg,
   output logic        oDp,
   output logic [3:0]  oAnodes,
   output logic        oScanTick
);
   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0]    r_cnt;
   logic [IDX_W-1:0] r_idx;
   state_t           r_state;
   logic [15:0]      r_digits;
   logic [3:0]       r_dp;

   logic             w_tick;
   logic             w_blank;
   logic             w_lit;
   logic [3:0]       w_code;
   logic [6:0]       w_dec;

   assign w_tick  = iEn && (r_cnt == CW'(CLK_DIV - 1));
   assign w_code  = r_digits[{r_idx, 2'b00} +: 4];
   // digit k is a leading zero when it and every higher digit are zero
   assign w_blank = BLANK_LEADING && (r_idx != '0) && ((r_digits >> {r_idx, 2'b00}) == 16'h0);
   assign w_lit   = iEn && (r_state == SHOW) && !w_blank;

   seg7_decoder u_dec (
      .i_code (w_code),
      .o_seg  (w_dec)
   );

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         r_digits <= '0;
         r_dp     <= '0;
      end else if (iLoad) begin
         r_digits <= iDigits;
         r_dp     <= iDp;
      end
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         r_cnt     <= '0;
         r_idx     <= '0;
         r_state   <= SHOW;
         oAnodes   <= {4{ACTIVE_LOW}};
         oSeg      <= {7{ACTIVE_LOW}};
         oDp       <= ACTIVE_LOW;
         oScanTick <= 1'b0;
      end else begin
         if (iEn) begin
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_state <= (r_state == SHOW && w_tick) ? GAP : SHOW;
            if (w_tick) r_idx <= r_idx + 1'b1;
         end
         oAnodes   <= (w_lit ? 4'b0001 << r_idx : 4'b0000) ^ {4{ACTIVE_LOW}};
         oSeg      <= (w_lit ? w_dec : OFF) ^ {7{ACTIVE_LOW}};
         oDp       <= (w_lit && r_dp[r_idx]) ^ ACTIVE_LOW;
         oScanTick <= w_tick;
      end
   end
endmodule
